// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared I2C types and constants for controller and target
// Purpose: target FSM state encoding, byte geometry and bus timing constants.
// Ports: none (package).
package i2c_pkg;

  localparam int I2C_BYTE_BITS = 8;
  localparam int I2C_IDX_W     = 2;

  // Controller bus timing in system clocks; the target's SYNC_STAGES+1 cycle
  // response latency must fit inside I2C_TLOW - I2C_TSU_DAT.
  localparam int I2C_TLOW      = 16;
  localparam int I2C_THIGH     = 16;
  localparam int I2C_TSU_DAT   = 8;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    WR_DATA,
    WR_ACK,
    RD_DATA,
    RD_ACK,
    WAIT_STOP
  } i2c_target_states_t;

endpackage

// File: rtl/i2c_bus_sync.sv
// rtl/i2c_bus_sync.sv - SCL/SDA synchronizer with edge, START and STOP detect
// Purpose: brings the asynchronous bus lines into clk and derives 1-cycle event pulses.
// Ports: clk, rst (async, active-high); scl, sda bus levels in;
//        sda_s synchronized SDA; scl_rise, scl_fall, start_det, stop_det pulses.
module i2c_bus_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic scl,
  input  logic sda,
  output logic sda_s,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  logic [SYNC_STAGES-1:0] scl_ff;
  logic [SYNC_STAGES-1:0] sda_ff;
  logic                   scl_d;
  logic                   sda_d;
  logic                   scl_s;

  // Reset to the idle bus level so leaving reset does not fake a START.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_ff <= '1;
      sda_ff <= '1;
      scl_d  <= 1'b1;
      sda_d  <= 1'b1;
    end else begin
      scl_ff <= {scl_ff[SYNC_STAGES-2:0], scl};
      sda_ff <= {sda_ff[SYNC_STAGES-2:0], sda};
      scl_d  <= scl_s;
      sda_d  <= sda_s;
    end
  end

  assign scl_s     = scl_ff[SYNC_STAGES-1];
  assign sda_s     = sda_ff[SYNC_STAGES-1];
  assign scl_rise  = scl_s & ~scl_d;
  assign scl_fall  = ~scl_s & scl_d;
  assign start_det = scl_s & scl_d & sda_d & ~sda_s;
  assign stop_det  = scl_s & scl_d & ~sda_d & sda_s;

endmodule

// File: rtl/i2c_target_responder.sv
// rtl/i2c_target_responder.sv - I2C target: address match, ACK, write/read byte streaming
// Purpose: oversampled I2C target driving SDA open-drain through sda_oe.
// Ports: clk, rst (async, active-high); scl, sda_in bus levels; sda_oe pull-low enable;
//        tx_data/tx_req/tx_idx read-byte host fetch; rx_valid/rx_data/rx_idx write-byte
//        delivery; addr_hit, rw_o, busy transaction status.
module i2c_target_responder
  import i2c_pkg::*;
#(
  parameter logic [6:0] TARGET_ADDR = 7'h42,
  parameter int         MAX_BYTES   = 3,
  parameter int         SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 scl,
  input  logic                 sda_in,
  output logic                 sda_oe,
  input  logic [7:0]           tx_data,
  output logic                 tx_req,
  output logic [I2C_IDX_W-1:0] tx_idx,
  output logic                 rx_valid,
  output logic [7:0]           rx_data,
  output logic [I2C_IDX_W-1:0] rx_idx,
  output logic                 addr_hit,
  output logic                 rw_o,
  output logic                 busy
);

  localparam logic [3:0] LAST_BIT = 4'(I2C_BYTE_BITS);
  localparam logic [2:0] MAX_B    = 3'(MAX_BYTES);

  logic sda_s, scl_rise, scl_fall, start_det, stop_det;

  i2c_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk       (clk),
    .rst       (rst),
    .scl       (scl),
    .sda       (sda_in),
    .sda_s     (sda_s),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det)
  );

  i2c_target_states_t   state;
  logic [3:0]           bit_cnt;
  logic [I2C_IDX_W-1:0] byte_cnt;
  logic [7:0]           shreg;
  logic [7:0]           tx_shreg;
  logic                 tx_pend;
  logic                 rd_ack;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      byte_cnt <= '0;
      shreg    <= '0;
      tx_shreg <= '0;
      tx_pend  <= 1'b0;
      rd_ack   <= 1'b0;
      sda_oe   <= 1'b0;
      tx_req   <= 1'b0;
      tx_idx   <= '0;
      rx_valid <= 1'b0;
      rx_data  <= '0;
      rx_idx   <= '0;
      addr_hit <= 1'b0;
      rw_o     <= 1'b0;
      busy     <= 1'b0;
    end else begin
      tx_req   <= 1'b0;
      rx_valid <= 1'b0;
      addr_hit <= 1'b0;
      // Host gets the whole cycle after tx_req to present tx_data.
      tx_pend  <= tx_req;
      if (tx_pend) tx_shreg <= tx_data;

      if (stop_det) begin
        state  <= IDLE;
        sda_oe <= 1'b0;
        busy   <= 1'b0;
      end else if (start_det) begin
        state    <= ADDR;
        bit_cnt  <= '0;
        byte_cnt <= '0;
        sda_oe   <= 1'b0;
        busy     <= 1'b1;
      end else begin
        case (state)
          ADDR: begin
            if (scl_rise && bit_cnt < LAST_BIT) begin
              shreg   <= {shreg[6:0], sda_s};
              bit_cnt <= bit_cnt + 4'd1;
            end else if (scl_fall && bit_cnt == LAST_BIT) begin
              bit_cnt <= '0;
              if (shreg[7:1] == TARGET_ADDR) begin
                state    <= ADDR_ACK;
                sda_oe   <= 1'b1;
                addr_hit <= 1'b1;
                rw_o     <= shreg[0];
              end else begin
                state  <= WAIT_STOP;
                sda_oe <= 1'b0;
              end
            end
          end
          ADDR_ACK: begin
            if (scl_rise && rw_o) begin
              tx_req <= 1'b1;
              tx_idx <= '0;
            end else if (scl_fall) begin
              bit_cnt <= '0;
              if (rw_o) begin
                state  <= RD_DATA;
                sda_oe <= ~tx_shreg[7];
              end else begin
                state  <= WR_DATA;
                sda_oe <= 1'b0;
              end
            end
          end
          WR_DATA: begin
            if (scl_rise && bit_cnt < LAST_BIT) begin
              shreg   <= {shreg[6:0], sda_s};
              bit_cnt <= bit_cnt + 4'd1;
            end else if (scl_fall && bit_cnt == LAST_BIT) begin
              if ({1'b0, byte_cnt} < MAX_B) begin
                rx_valid <= 1'b1;
                rx_data  <= shreg;
                rx_idx   <= byte_cnt;
                sda_oe   <= 1'b1;
                state    <= WR_ACK;
              end else begin
                sda_oe <= 1'b0;
                state  <= WAIT_STOP;
              end
            end
          end
          WR_ACK: begin
            if (scl_fall) begin
              sda_oe  <= 1'b0;
              bit_cnt <= '0;
              if (byte_cnt != 2'd3) byte_cnt <= byte_cnt + 2'd1;
              state   <= WR_DATA;
            end
          end
          RD_DATA: begin
            if (scl_rise && bit_cnt < LAST_BIT) begin
              bit_cnt <= bit_cnt + 4'd1;
            end else if (scl_fall) begin
              if (bit_cnt < LAST_BIT) begin
                tx_shreg <= {tx_shreg[6:0], 1'b0};
                sda_oe   <= ~tx_shreg[6];
              end else begin
                sda_oe  <= 1'b0;
                bit_cnt <= '0;
                state   <= RD_ACK;
              end
            end
          end
          RD_ACK: begin
            if (scl_rise) begin
              rd_ack <= ~sda_s;
              if (!sda_s) begin
                tx_req <= 1'b1;
                tx_idx <= byte_cnt + 2'd1;
              end
            end else if (scl_fall) begin
              if (rd_ack && ({1'b0, byte_cnt} + 3'd1 < MAX_B)) begin
                byte_cnt <= byte_cnt + 2'd1;
                bit_cnt  <= '0;
                sda_oe   <= ~tx_shreg[7];
                state    <= RD_DATA;
              end else begin
                sda_oe <= 1'b0;
                state  <= WAIT_STOP;
              end
            end
          end
          WAIT_STOP: sda_oe <= 1'b0;
          default:   sda_oe <= 1'b0;
        endcase
      end
    end
  end

endmodule
